// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned NB_PC            = 32;
  localparam int unsigned NB_INSTRUCTION   = 32;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: write-enabled, flushes to a NOP bubble with valid cleared.
module if_id_register #(
  parameter int unsigned NB_PC           = 32,
  parameter int unsigned NB_INSTRUCTION  = 32,
  parameter logic [NB_INSTRUCTION-1:0] NOP_INSTRUCTION = '0
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_write,
  input  logic                      i_flush,
  input  logic [NB_INSTRUCTION-1:0] i_instruction,
  input  logic [NB_PC-1:0]          i_pc_plus4,
  output logic [NB_INSTRUCTION-1:0] o_instruction,
  output logic [NB_PC-1:0]          o_pc_plus4,
  output logic                      o_valid
);

  logic [NB_INSTRUCTION-1:0] instruction_q;
  logic [NB_PC-1:0]          pc_plus4_q;
  logic                      valid_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      instruction_q <= NOP_INSTRUCTION;
      pc_plus4_q    <= '0;
      valid_q       <= 1'b0;
    end else if (i_write) begin
      if (i_flush) begin
        instruction_q <= NOP_INSTRUCTION;
        pc_plus4_q    <= '0;
        valid_q       <= 1'b0;
      end else begin
        instruction_q <= i_instruction;
        pc_plus4_q    <= i_pc_plus4;
        valid_q       <= 1'b1;
      end
    end
  end

  assign o_instruction = instruction_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_valid       = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, halt FSM, fetch counter and IF/ID register.
module if_stage #(
  parameter int unsigned NB_PC            = mips_pkg::NB_PC,
  parameter int unsigned NB_INSTRUCTION   = mips_pkg::NB_INSTRUCTION,
  parameter int unsigned NB_COUNTER       = 32,
  parameter logic [NB_INSTRUCTION-1:0] HALT_INSTRUCTION = NB_INSTRUCTION'(mips_pkg::HALT_INSTRUCTION),
  parameter logic [NB_INSTRUCTION-1:0] NOP_INSTRUCTION  = NB_INSTRUCTION'(mips_pkg::NOP_INSTRUCTION)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_pc_write,
  input  logic                      i_if_flush,
  input  logic                      i_jump,
  input  logic [NB_PC-1:0]          i_jump_target,
  input  logic                      i_branch_taken,
  input  logic [NB_PC-1:0]          i_branch_target,
  output logic [NB_PC-1:0]          o_imem_addr,
  input  logic [NB_INSTRUCTION-1:0] i_imem_data,
  output logic [NB_INSTRUCTION-1:0] o_instruction_if_id,
  output logic [NB_PC-1:0]          o_pc_plus4_if_id,
  output logic                      o_valid_if_id,
  output logic                      o_halted,
  output logic [NB_COUNTER-1:0]     o_fetch_count,
  output logic [NB_PC-1:0]          o_pc
);

  import mips_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [NB_PC-1:0]      pc_q, pc_d;
  logic [NB_COUNTER-1:0] count_q, count_d;
  logic [NB_PC-1:0]      pc_plus4;
  logic [NB_PC-1:0]      next_pc;
  logic                  is_halt;
  logic                  ifid_write;
  logic                  ifid_flush;

  assign pc_plus4 = pc_q + NB_PC'(PC_STEP);
  assign is_halt  = (i_imem_data == HALT_INSTRUCTION);

  // Jump resolved in ID beats a taken branch; otherwise fall through.
  always_comb begin
    next_pc = pc_plus4;
    if (i_jump)              next_pc = i_jump_target;
    else if (i_branch_taken) next_pc = i_branch_target;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Stall and debug-freeze simply leave every defaulted hold in place.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    if (i_enable) begin
      case (state_q)
        ST_RUN: begin
          if (i_pc_write) begin
            ifid_write = 1'b1;
            if (i_if_flush) begin
              ifid_flush = 1'b1;
              pc_d       = next_pc;
            end else begin
              count_d = count_q + NB_COUNTER'(1);
              if (is_halt) state_d = ST_HALTED;
              else         pc_d    = next_pc;
            end
          end
        end
        ST_HALTED: begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  if_id_register #(
    .NB_PC           (NB_PC),
    .NB_INSTRUCTION  (NB_INSTRUCTION),
    .NOP_INSTRUCTION (NOP_INSTRUCTION)
  ) u_if_id_register (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_write       (ifid_write),
    .i_flush       (ifid_flush),
    .i_instruction (i_imem_data),
    .i_pc_plus4    (pc_plus4),
    .o_instruction (o_instruction_if_id),
    .o_pc_plus4    (o_pc_plus4_if_id),
    .o_valid       (o_valid_if_id)
  );

  assign o_imem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then randomized traffic vs a reference model.
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        i_clock = 1'b0;
  logic        i_reset, i_enable, i_pc_write, i_if_flush;
  logic        i_jump, i_branch_taken;
  logic [31:0] i_jump_target, i_branch_target;
  logic [31:0] o_imem_addr, i_imem_data;
  logic [31:0] o_instruction_if_id, o_pc_plus4_if_id, o_pc, o_fetch_count;
  logic        o_valid_if_id, o_halted;

  logic [31:0] halt_addr;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted;

  always #5 i_clock = ~i_clock;

  if_stage dut (
    .i_clock             (i_clock),
    .i_reset             (i_reset),
    .i_enable            (i_enable),
    .i_pc_write          (i_pc_write),
    .i_if_flush          (i_if_flush),
    .i_jump              (i_jump),
    .i_jump_target       (i_jump_target),
    .i_branch_taken      (i_branch_taken),
    .i_branch_target     (i_branch_target),
    .o_imem_addr         (o_imem_addr),
    .i_imem_data         (i_imem_data),
    .o_instruction_if_id (o_instruction_if_id),
    .o_pc_plus4_if_id    (o_pc_plus4_if_id),
    .o_valid_if_id       (o_valid_if_id),
    .o_halted            (o_halted),
    .o_fetch_count       (o_fetch_count),
    .o_pc                (o_pc)
  );

  // Instruction memory contents: bit 0 forced low so only halt_addr holds HALT.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return HALT;
    return (a ^ 32'h5A5A_5A50) & 32'hFFFF_FFFE;
  endfunction

  assign i_imem_data = mem_word(o_imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one rising edge, straight from the stage's priority rules.
  always @(posedge i_clock) begin
    logic [31:0] npc, word;
    npc  = i_jump ? i_jump_target : (i_branch_taken ? i_branch_target : m_pc + 32'd4);
    word = mem_word(m_pc);
    if (i_reset) begin
      m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_halted = 0; m_count = 0;
    end else if (!i_enable) begin
      // frozen
    end else if (m_halted) begin
      m_instr = NOP; m_valid = 0;
    end else if (!i_pc_write) begin
      // stalled
    end else if (i_if_flush) begin
      m_instr = NOP; m_valid = 0; m_pc = npc;
    end else begin
      m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1; m_count = m_count + 1;
      if (word == HALT) m_halted = 1;
      else              m_pc = npc;
    end
  end

  always @(negedge i_clock) begin
    if (chk_en) begin
      chk("pc", o_pc, m_pc);
      chk("imem_addr", o_imem_addr, m_pc);
      chk("instr", o_instruction_if_id, m_instr);
      chk("valid", 32'(o_valid_if_id), 32'(m_valid));
      chk("halted", 32'(o_halted), 32'(m_halted));
      chk("count", o_fetch_count, m_count);
      if (m_valid) chk("pc_plus4", o_pc_plus4_if_id, m_pc4);
    end
  end

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic pw, input logic fl,
                       input logic jp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt);
    i_enable = en; i_pc_write = pw; i_if_flush = fl;
    i_jump = jp; i_jump_target = jt; i_branch_taken = br; i_branch_target = bt;
  endtask

  initial begin
    halt_addr = 32'h20;
    i_reset = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0);
    tick; tick;
    chk_en = 1'b1;
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instruction_if_id, NOP);
    chk("rst_valid", 32'(o_valid_if_id), 32'h0);
    chk("rst_count", o_fetch_count, 32'h0);

    // Sequential fetch
    i_reset = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0);
    tick;
    chk("seq_pc4", o_pc, 32'h4);
    chk("seq_instr0", o_instruction_if_id, 32'h5A5A_5A50);
    tick;
    chk("seq_pc8", o_pc, 32'h8);

    // Stall with flush and branch pending: everything holds
    drive(1, 0, 1, 0, 0, 1, 32'h40);
    tick; tick;
    chk("stall_pc", o_pc, 32'h8);
    chk("stall_instr", o_instruction_if_id, 32'h5A5A_5A54);
    chk("stall_count", o_fetch_count, 32'h2);
    drive(1, 1, 0, 0, 0, 0, 0);
    tick;
    chk("unstall_pc", o_pc, 32'hC);
    chk("unstall_count", o_fetch_count, 32'h3);
    tick;
    chk("seq_pc10", o_pc, 32'h10);

    // Taken branch with flush
    drive(1, 1, 1, 0, 0, 1, 32'h40);
    tick;
    chk("br_pc", o_pc, 32'h40);
    chk("br_valid", 32'(o_valid_if_id), 32'h0);
    chk("br_instr", o_instruction_if_id, NOP);
    chk("br_count", o_fetch_count, 32'h4);

    // Jump beats branch
    drive(1, 1, 0, 1, 32'h100, 1, 32'h40);
    tick;
    chk("jmp_pc", o_pc, 32'h100);
    chk("jmp_instr", o_instruction_if_id, 32'h5A5A_5A10);
    chk("jmp_pc4", o_pc_plus4_if_id, 32'h44);

    // Debug freeze
    drive(0, 1, 1, 1, 32'h200, 0, 0);
    tick;
    chk("frz_pc", o_pc, 32'h100);
    chk("frz_count", o_fetch_count, 32'h5);
    chk("frz_valid", 32'(o_valid_if_id), 32'h1);

    // HALT fetched under flush is discarded
    halt_addr = 32'h100;
    drive(1, 1, 1, 1, 32'h20, 0, 0);
    tick;
    chk("hflush_pc", o_pc, 32'h20);
    chk("hflush_halted", 32'(o_halted), 32'h0);

    // Real HALT at 0x20
    halt_addr = 32'h20;
    drive(1, 1, 0, 0, 0, 0, 0);
    tick;
    chk("halt_instr", o_instruction_if_id, HALT);
    chk("halt_valid", 32'(o_valid_if_id), 32'h1);
    chk("halt_pc", o_pc, 32'h20);
    chk("halt_flag", 32'(o_halted), 32'h1);
    chk("halt_count", o_fetch_count, 32'h6);
    drive(1, 1, 0, 1, 32'h300, 0, 0);
    tick;
    chk("halted_instr", o_instruction_if_id, NOP);
    chk("halted_valid", 32'(o_valid_if_id), 32'h0);
    chk("halted_pc", o_pc, 32'h20);

    // Reset out of HALTED
    i_reset = 1'b1;
    tick;
    chk("rst2_pc", o_pc, 32'h0);
    chk("rst2_halted", 32'(o_halted), 32'h0);
    chk("rst2_count", o_fetch_count, 32'h0);

    // PC+4 wrap
    i_reset = 1'b0;
    drive(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick;
    drive(1, 1, 0, 0, 0, 0, 0);
    tick;
    chk("wrap_pc", o_pc, 32'h0);
    chk("wrap_pc4", o_pc_plus4_if_id, 32'h0);

    // Randomized traffic against the model
    halt_addr = 32'h40;
    for (int n = 0; n < 3000; n++) begin
      i_reset         = ($urandom_range(0, 63) == 0);
      i_enable        = ($urandom_range(0, 7) != 0);
      i_pc_write      = ($urandom_range(0, 3) != 0);
      i_if_flush      = ($urandom_range(0, 3) == 0);
      i_jump          = ($urandom_range(0, 7) == 0);
      i_branch_taken  = ($urandom_range(0, 3) == 0);
      i_jump_target   = 32'($urandom_range(0, 127)) << 2;
      i_branch_target = ($urandom_range(0, 15) == 0) ? 32'($urandom) : (32'($urandom_range(0, 127)) << 2);
      tick;
    end

    @(negedge i_clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: program counter, next-PC selection, and the IF/ID pipeline register.
- Directly upstream of ID and of the hazard unit. Consumes the hazard unit's stall (PC/IF-ID write enable) and flush outputs, plus the branch/jump targets resolved in ID.
- Produces the IF/ID instruction and PC fields read by the hazard unit and decoder.
- Detects HALT and exposes halted status and a fetch counter to the debug unit.

Parameters:
- NB_PC, 32, PC and address width
- NB_INSTRUCTION, 32, instruction width
- NB_COUNTER, 32, fetch counter width
- HALT_INSTRUCTION, 32'hFFFF_FFFF, halt encoding
- NOP_INSTRUCTION, 32'h0000_0000, bubble encoding

Ports:
- i_clock  input  1  rising-edge clock
- i_reset  input  1  synchronous, active-high reset
- i_enable  input  1  pipeline advance (debug run/step); 0 = freeze all state
- i_pc_write  input  1  hazard "no risk"; 0 = stall PC and IF/ID
- i_if_flush  input  1  hazard flush; IF/ID loads NOP
- i_jump  input  1  jump resolved in ID
- i_jump_target  input  NB_PC  jump address
- i_branch_taken  input  1  branch taken in ID
- i_branch_target  input  NB_PC  branch address
- o_imem_addr  output  NB_PC  instruction memory address (= current PC)
- i_imem_data  input  NB_INSTRUCTION  instruction memory data, combinational read
- o_instruction_if_id  output  NB_INSTRUCTION  IF/ID instruction
- o_pc_plus4_if_id  output  NB_PC  IF/ID PC+4
- o_valid_if_id  output  1  IF/ID holds a real fetched instruction (not a bubble)
- o_halted  output  1  sticky halt flag
- o_fetch_count  output  NB_COUNTER  instructions accepted into IF/ID
- o_pc  output  NB_PC  current PC, for debug

Behaviour:
- Clocking and reset: single clock i_clock. Reset is synchronous, active-high on i_reset, and overrides everything.
- Reset values:
  - PC = 0
  - o_instruction_if_id = NOP
  - o_pc_plus4_if_id = 0
  - o_valid_if_id = 0
  - o_halted = 0
  - o_fetch_count = 0
- Reset asserted mid-stall or while halted returns the stage to the reset values above at the next edge.
- Addressing: o_imem_addr = PC, combinational. Instruction memory has zero-latency read, so i_imem_data is valid in the same cycle.
- PC+4 is a modulo-2^NB_PC add; 0xFFFF_FFFC + 4 wraps to 0.
- States (2): RUN, HALTED.
- Per rising edge, evaluated in this priority order:
  1. i_reset: reset.
  2. !i_enable: all registers hold, including the counter.
  3. HALTED: PC holds; IF/ID loads NOP with valid=0; counter holds; flush/redirect ignored.
  4. RUN with !i_pc_write (stall): PC and IF/ID hold; counter holds. i_if_flush and redirects are ignored this cycle, because the branch in ID is re-evaluated once the stall clears.
  5. RUN with i_if_flush:
     - IF/ID loads NOP, valid=0.
     - PC loads next-PC.
     - Counter holds.
     - HALT detection is suppressed; a HALT fetched under flush is discarded.
  6. RUN otherwise:
     - IF/ID loads i_imem_data, PC+4, valid=1.
     - Counter increments (wraps).
     - PC loads next-PC.
- Next-PC priority: i_jump → i_jump_target; else i_branch_taken → i_branch_target; else PC+4.
- Target bits [1:0] are passed through unmodified; alignment is the decoder's responsibility.
- HALT: in case 6, if i_imem_data == HALT_INSTRUCTION:
  - HALT is latched into IF/ID (valid=1, counted), so it propagates down the pipe.
  - PC holds instead of advancing.
  - State goes to HALTED; o_halted = 1 from the next cycle.
  - Only reset exits HALTED.
- Latency: an instruction at PC appears on o_instruction_if_id one enabled, unstalled edge after PC is presented.

Decomposition:
- Shared package mips_pkg: NOP_INSTRUCTION, HALT_INSTRUCTION, PC_STEP (4), NB_PC, NB_INSTRUCTION.
- One natural sub-module: if_id_register (write-enable, flush-to-NOP, valid bit).
- PC, next-PC mux, halt FSM and counter stay in if_stage.

Test Plan:
1. Reset, then enable with memory holding sequential non-halt words → PC steps 0, 4, 8, 12; o_instruction_if_id follows one cycle later; o_fetch_count = 3 after 3 edges.
2. i_pc_write = 0 for 2 cycles at PC = 8, with i_if_flush = 1 and i_branch_taken = 1 (target 0x40) during the stall → PC stays 8, IF/ID unchanged, counter unchanged; PC advances to 12 when the stall releases.
3. i_branch_taken = 1, target 0x40, i_if_flush = 1 at PC = 0x10 → next PC = 0x40, IF/ID = NOP with valid = 0; counter unchanged.
4. i_jump = 1 (target 0x100) and i_branch_taken = 1 (target 0x40) in the same cycle → next PC = 0x100.
5. HALT at address 0x20 → IF/ID = 0xFFFF_FFFF, valid = 1; PC frozen at 0x20; o_halted = 1 next cycle; then NOPs into IF/ID. HALT fetched under flush → no halt.
6. i_enable = 0 mid-run → full freeze; reset asserted while HALTED → PC = 0, o_halted = 0 on the next edge.
